vga_sync_decoder: RTL and testbench



---
 rtl/vga_sync_decoder_pkg.sv | 18 +
 rtl/vga_sync_edge_detect.sv | 38 +++
 rtl/vga_sync_decoder.sv | 203 ++++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_sync_decoder_pkg.sv
// Shared definitions for the VGA sync decoder: FSM state codes, default
// counter widths and the SVGA 800x600@72 reference geometry.
package vga_sync_decoder_pkg;

  localparam int H_WIDTH_DEF  = 11;
  localparam int V_WIDTH_DEF  = 10;

  // SVGA reference totals (pixels per line, lines per frame)
  localparam int SVGA_H_TOTAL = 1040;
  localparam int SVGA_V_TOTAL = 666;

  typedef logic [1:0] state_t;

  localparam state_t ST_SEARCH = 2'd0;
  localparam state_t ST_TRACK  = 2'd1;
  localparam state_t ST_LOCKED = 2'd2;

endpackage

// File: rtl/vga_sync_edge_detect.sv
// sync_edge_detect: brings one raw sync into the pixel clock domain through a
// 2-flop synchroniser, applies the active polarity and emits a registered
// one-cycle pulse on the inactive->active transition (3 cycles after the pin).
module sync_edge_detect
  import vga_sync_decoder_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sync_i,
  input  logic pol_low_i,
  output logic synced_o,
  output logic edge_o
);

  logic s1_q, s2_q, act_q, edge_q;
  logic act;

  assign act = s2_q ^ pol_low_i;

  // synchroniser, active-level history and leading-edge pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      act_q  <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      s1_q   <= sync_i;
      s2_q   <= s1_q;
      act_q  <= act;
      edge_q <= act & ~act_q;
    end
  end

  assign synced_o = s2_q;
  assign edge_o   = edge_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: measures incoming VGA line/frame lengths, recovers the
// current pixel/line position and flags lock once timing is stable.
// Optional automatic sync polarity detection: VGA_SYNC_POLARITY_DETECT_EN.
module vga_sync_decoder
  import vga_sync_decoder_pkg::*;
#(
  parameter int H_WIDTH           = H_WIDTH_DEF,
  parameter int V_WIDTH           = V_WIDTH_DEF,
  parameter int LOCK_FRAMES       = 2,
  parameter int H_SYNC_ACTIVE_LOW = 0,
  parameter int V_SYNC_ACTIVE_LOW = 0
) (
  input  logic               pixel_clock,
  input  logic               reset,
  input  logic               h_synch_in,
  input  logic               v_synch_in,
  output logic [H_WIDTH-1:0] pixel_count,
  output logic [V_WIDTH-1:0] line_count,
  output logic [H_WIDTH-1:0] h_total,
  output logic [V_WIDTH-1:0] v_total,
  output logic               locked,
  output logic               h_pol_low,
  output logic               v_pol_low,
  output logic               frame_start
);

  localparam logic [H_WIDTH-1:0] H_MAX  = '1;
  localparam logic [V_WIDTH-1:0] V_MAX  = '1;
  localparam logic [H_WIDTH-1:0] H_ONE  = 1;
  localparam logic [V_WIDTH-1:0] V_ONE  = 1;
  localparam logic [3:0]         LOCK_N = 4'(LOCK_FRAMES);

  logic h_pol, v_pol, h_syn, v_syn, h_edge, v_edge, pol_chg;

  sync_edge_detect u_h_sync (
    .clk_i(pixel_clock), .rst_ni(reset), .sync_i(h_synch_in),
    .pol_low_i(h_pol), .synced_o(h_syn), .edge_o(h_edge)
  );

  sync_edge_detect u_v_sync (
    .clk_i(pixel_clock), .rst_ni(reset), .sync_i(v_synch_in),
    .pol_low_i(v_pol), .synced_o(v_syn), .edge_o(v_edge)
  );

`ifdef VGA_SYNC_POLARITY_DETECT_EN
  logic               h_pol_q, v_pol_q, h_pvld_q, v_pvld_q;
  logic [H_WIDTH-1:0] h_hi_q, h_lo_q;
  logic [V_WIDTH-1:0] v_hi_q, v_lo_q;
  logic               h_pol_new, v_pol_new;
  logic               unused_par;

  // shorter phase is the sync pulse; a tie keeps the current decision
  assign h_pol_new = (h_lo_q < h_hi_q) ? 1'b1 : (h_hi_q < h_lo_q) ? 1'b0 : h_pol_q;
  assign v_pol_new = (v_lo_q < v_hi_q) ? 1'b1 : (v_hi_q < v_lo_q) ? 1'b0 : v_pol_q;
  assign pol_chg   = (h_edge & h_pvld_q & (h_pol_new != h_pol_q)) |
                     (v_edge & v_pvld_q & (v_pol_new != v_pol_q));
  assign h_pol      = h_pol_q;
  assign v_pol      = v_pol_q;
  assign unused_par = (H_SYNC_ACTIVE_LOW != 0) ^ (V_SYNC_ACTIVE_LOW != 0);

  // high/low phase counters per period; decision applied at the period end
  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      h_pol_q  <= 1'b0;
      v_pol_q  <= 1'b0;
      h_pvld_q <= 1'b0;
      v_pvld_q <= 1'b0;
      h_hi_q   <= '0;
      h_lo_q   <= '0;
      v_hi_q   <= '0;
      v_lo_q   <= '0;
    end else begin
      if (h_edge) begin
        h_hi_q   <= h_syn ? H_ONE : '0;
        h_lo_q   <= h_syn ? '0 : H_ONE;
        h_pvld_q <= 1'b1;
        if (h_pvld_q) h_pol_q <= h_pol_new;
      end else begin
        if (h_syn  && h_hi_q != H_MAX) h_hi_q <= h_hi_q + H_ONE;
        if (!h_syn && h_lo_q != H_MAX) h_lo_q <= h_lo_q + H_ONE;
      end
      if (v_edge) begin
        v_hi_q   <= (h_edge && v_syn)  ? V_ONE : '0;
        v_lo_q   <= (h_edge && !v_syn) ? V_ONE : '0;
        v_pvld_q <= 1'b1;
        if (v_pvld_q) v_pol_q <= v_pol_new;
      end else if (h_edge) begin
        if (v_syn  && v_hi_q != V_MAX) v_hi_q <= v_hi_q + V_ONE;
        if (!v_syn && v_lo_q != V_MAX) v_lo_q <= v_lo_q + V_ONE;
      end
    end
  end
`else
  logic unused_syn;

  assign h_pol      = (H_SYNC_ACTIVE_LOW != 0);
  assign v_pol      = (V_SYNC_ACTIVE_LOW != 0);
  assign pol_chg    = 1'b0;
  assign unused_syn = h_syn ^ v_syn;
`endif

  logic [H_WIDTH-1:0] pix_q, pix_d, htot_q, htot_d, h_meas;
  logic [V_WIDTH-1:0] line_q, line_d, vtot_q, vtot_d, v_meas, ref_q, ref_d;
  logic [3:0]         mcnt_q, mcnt_d, mcnt_inc;
  state_t             st_q, st_d;
  logic               ref_vld_q, ref_vld_d, hmis_q, hmis_d, fs_q;
  logic               sat, h_mis_now, frame_ok;

  assign h_meas    = pix_q + H_ONE;
  assign v_meas    = line_q + V_ONE;
  assign mcnt_inc  = mcnt_q + 4'd1;
  assign sat       = (pix_q == H_MAX) | (line_q == V_MAX) | pol_chg;
  assign h_mis_now = h_edge & (htot_q != '0) & (h_meas != htot_q);
  // a frame matches when its length repeats and no line in it changed length
  assign frame_ok  = ref_vld_q & (v_meas == ref_q) & ~hmis_q & ~h_mis_now;

  // position counters, period capture and lock FSM next state
  always_comb begin
    pix_d = pix_q;
    if (h_edge) pix_d = '0;
    else if (pix_q != H_MAX) pix_d = pix_q + H_ONE;

    line_d = line_q;
    if (v_edge) line_d = '0;
    else if (h_edge && line_q != V_MAX) line_d = line_q + V_ONE;

    htot_d    = h_edge ? h_meas : htot_q;
    vtot_d    = v_edge ? v_meas : vtot_q;
    hmis_d    = v_edge ? 1'b0 : (hmis_q | h_mis_now);
    st_d      = st_q;
    mcnt_d    = mcnt_q;
    ref_d     = ref_q;
    ref_vld_d = ref_vld_q;

    case (st_q)
      ST_SEARCH: if (v_edge) begin
        st_d      = ST_TRACK;
        mcnt_d    = '0;
        ref_vld_d = 1'b0;
      end
      ST_TRACK: if (v_edge) begin
        mcnt_d    = frame_ok ? mcnt_inc : '0;
        ref_d     = v_meas;
        ref_vld_d = 1'b1;
        if (frame_ok && mcnt_inc == LOCK_N) st_d = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (v_edge) ref_d = v_meas;
        if (h_mis_now || (v_edge && v_meas != ref_q)) begin
          st_d   = ST_TRACK;
          mcnt_d = '0;
        end
      end
      default: st_d = ST_SEARCH;
    endcase

    // counter overflow or polarity flip invalidates every measurement
    if (sat) begin
      st_d      = ST_SEARCH;
      htot_d    = '0;
      vtot_d    = '0;
      mcnt_d    = '0;
      ref_vld_d = 1'b0;
    end
  end

  // state registers
  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      pix_q     <= '0;
      line_q    <= '0;
      htot_q    <= '0;
      vtot_q    <= '0;
      ref_q     <= '0;
      ref_vld_q <= 1'b0;
      hmis_q    <= 1'b0;
      mcnt_q    <= '0;
      st_q      <= ST_SEARCH;
      fs_q      <= 1'b0;
    end else begin
      pix_q     <= pix_d;
      line_q    <= line_d;
      htot_q    <= htot_d;
      vtot_q    <= vtot_d;
      ref_q     <= ref_d;
      ref_vld_q <= ref_vld_d;
      hmis_q    <= hmis_d;
      mcnt_q    <= mcnt_d;
      st_q      <= st_d;
      fs_q      <= v_edge;
    end
  end

  assign pixel_count = pix_q;
  assign line_count  = line_q;
  assign h_total     = htot_q;
  assign v_total     = vtot_q;
  assign locked      = (st_q == ST_LOCKED);
  assign h_pol_low   = h_pol;
  assign v_pol_low   = v_pol;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a scaled-down raster
// (40/44 pixels x 12 lines) so several frames fit in a short run.
module tb_vga_sync_decoder;

  localparam int HS_W = 4, VS_W = 2, HT0 = 40, HT1 = 44, VT = 12;
  localparam int BUDGET = 3000;

  logic        clk = 1'b0, rst_n = 1'b0, hs, vs;
  logic [10:0] pixel_count, h_total;
  logic [9:0]  line_count, v_total;
  logic        locked, h_pol_low, v_pol_low, frame_start;

  int n_chk = 0, n_fail = 0;
  bit gen_en = 1'b0, hold = 1'b0, neg = 1'b0;
  int ht = HT0, ht_req = HT0, hcnt = 0, vcnt = 0;
  int h_rise = 0, v_rise = 0;

  vga_sync_decoder #(
    .H_WIDTH(11), .V_WIDTH(10), .LOCK_FRAMES(2),
    .H_SYNC_ACTIVE_LOW(0), .V_SYNC_ACTIVE_LOW(0)
  ) dut (
    .pixel_clock(clk), .reset(rst_n), .h_synch_in(hs), .v_synch_in(vs),
    .pixel_count(pixel_count), .line_count(line_count),
    .h_total(h_total), .v_total(v_total), .locked(locked),
    .h_pol_low(h_pol_low), .v_pol_low(v_pol_low), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // raster generator: pins change 2 time units after a rising clock edge;
  // vsync leading edge always coincides with an hsync leading edge
  initial begin
    hs = 1'b0;
    vs = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (!gen_en) begin
        hcnt = 0; vcnt = 0; ht = ht_req; hs = neg; vs = neg;
      end else if (hold) begin
        hs = neg;
      end else begin
        hs = (hcnt < HS_W) ^ neg;
        vs = (vcnt < VS_W) ^ neg;
        if (hcnt == 0) h_rise++;
        if (hcnt == 0 && vcnt == 0) v_rise++;
        hcnt++;
        if (hcnt == ht) begin
          hcnt = 0;
          vcnt++;
          if (vcnt == VT) begin vcnt = 0; ht = ht_req; end
        end
      end
    end
  end

  task automatic wait_rise(input bit is_v, input int k, output bit ok);
    int n = 0;
    while (((is_v ? v_rise : h_rise) < k) && n < BUDGET) begin
      @(negedge clk); n++;
    end
    ok = ((is_v ? v_rise : h_rise) >= k);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++; if (pixel_count !== 11'd0) begin n_fail++; $display("FAIL rst_pix: got %0d want 0", pixel_count); end
    n_chk++; if (line_count !== 10'd0) begin n_fail++; $display("FAIL rst_line: got %0d want 0", line_count); end
    n_chk++; if ({h_total, v_total} !== 21'd0) begin n_fail++; $display("FAIL rst_totals: got %0d/%0d want 0/0", h_total, v_total); end
    n_chk++; if ({locked, frame_start} !== 2'b00) begin n_fail++; $display("FAIL rst_flags: got %b want 00", {locked, frame_start}); end
    n_chk++; if ({h_pol_low, v_pol_low} !== 2'b00) begin n_fail++; $display("FAIL rst_pol: got %b want 00", {h_pol_low, v_pol_low}); end
  endtask

  task automatic test_lock(input string tag);
    int v0, h0;
    bit ok;
    v0 = v_rise; h0 = h_rise; ht_req = HT0;
    @(negedge clk); rst_n = 1'b1; gen_en = 1'b1;
    wait_rise(1'b0, h0 + 2, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL %s_h2_timeout: got %0d rises want %0d", tag, h_rise - h0, 2); end
    repeat (4) @(negedge clk);
    n_chk++; if (h_total !== 11'd40) begin n_fail++; $display("FAIL %s_htotal: got %0d want 40", tag, h_total); end
    wait_rise(1'b1, v0 + 2, ok);
    repeat (3) @(negedge clk);
    n_chk++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL %s_fs_early: got %b want 0", tag, frame_start); end
    @(negedge clk);
    n_chk++; if (v_total !== 10'd12) begin n_fail++; $display("FAIL %s_vtotal: got %0d want 12", tag, v_total); end
    n_chk++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL %s_fs: got %b want 1", tag, frame_start); end
    n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL %s_lock_v2: got %b want 0", tag, locked); end
    wait_rise(1'b1, v0 + 4, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL %s_v4_timeout: got %0d rises want 4", tag, v_rise - v0); end
    repeat (3) @(negedge clk);
    n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL %s_lock_early: got %b want 0", tag, locked); end
    @(negedge clk);
    n_chk++; if (locked !== 1'b1) begin n_fail++; $display("FAIL %s_lock: got %b want 1", tag, locked); end
    n_chk++; if (pixel_count !== 11'd0) begin n_fail++; $display("FAIL %s_pix0: got %0d want 0", tag, pixel_count); end
    @(negedge clk);
    n_chk++; if (pixel_count !== 11'd1) begin n_fail++; $display("FAIL %s_pix1: got %0d want 1", tag, pixel_count); end
    n_chk++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL %s_fs_pulse: got %b want 0", tag, frame_start); end
  endtask

  task automatic test_coincident();
    bit ok;
    wait_rise(1'b1, v_rise + 1, ok);
    repeat (3) @(negedge clk);
    n_chk++; if (line_count !== 10'd11) begin n_fail++; $display("FAIL coin_last_line: got %0d want 11", line_count); end
    @(negedge clk);
    n_chk++; if (line_count !== 10'd0) begin n_fail++; $display("FAIL coin_line0: got %0d want 0", line_count); end
    n_chk++; if (v_total !== 10'd12) begin n_fail++; $display("FAIL coin_vtotal: got %0d want 12", v_total); end
    n_chk++; if ({locked, frame_start} !== 2'b11) begin n_fail++; $display("FAIL coin_flags: got %b want 11", {locked, frame_start}); end
    @(negedge clk);
    n_chk++; if ({line_count, frame_start} !== 11'd0) begin n_fail++; $display("FAIL coin_after: got line %0d fs %b want 0 0", line_count, frame_start); end
  endtask

  task automatic test_line_change();
    int v0, h1;
    bit ok;
    v0 = v_rise; ht_req = HT1;
    wait_rise(1'b1, v0 + 1, ok);
    h1 = h_rise;
    wait_rise(1'b0, h1 + 1, ok);
    repeat (3) @(negedge clk);
    n_chk++; if (locked !== 1'b1) begin n_fail++; $display("FAIL chg_hold_lock: got %b want 1", locked); end
    @(negedge clk);
    n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL chg_drop: got %b want 0", locked); end
    n_chk++; if (h_total !== 11'd44) begin n_fail++; $display("FAIL chg_htotal: got %0d want 44", h_total); end
    wait_rise(1'b1, v0 + 3, ok);
    repeat (4) @(negedge clk);
    n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL chg_2nd_edge: got %b want 0", locked); end
    wait_rise(1'b1, v0 + 4, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL chg_timeout: got %0d rises want 4", v_rise - v0); end
    repeat (3) @(negedge clk);
    n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL chg_relock_early: got %b want 0", locked); end
    @(negedge clk);
    n_chk++; if (locked !== 1'b1) begin n_fail++; $display("FAIL chg_relock: got %b want 1", locked); end
  endtask

  task automatic test_saturate();
    bit ok;
    wait_rise(1'b1, v_rise + 1, ok);
    wait_rise(1'b0, h_rise + 3, ok);
    hold = 1'b1;
    repeat (4) @(negedge clk);
    n_chk++; if (pixel_count !== 11'd0) begin n_fail++; $display("FAIL sat_start: got %0d want 0", pixel_count); end
    repeat (2047) @(negedge clk);
    n_chk++; if (pixel_count !== 11'd2047) begin n_fail++; $display("FAIL sat_pix: got %0d want 2047", pixel_count); end
    n_chk++; if (locked !== 1'b1) begin n_fail++; $display("FAIL sat_lock_before: got %b want 1", locked); end
    @(negedge clk);
    n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL sat_lock_after: got %b want 0", locked); end
    n_chk++; if ({h_total, v_total} !== 21'd0) begin n_fail++; $display("FAIL sat_totals: got %0d/%0d want 0/0", h_total, v_total); end
    n_chk++; if (pixel_count !== 11'd2047) begin n_fail++; $display("FAIL sat_hold: got %0d want 2047", pixel_count); end
    hold = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    wait_rise(1'b0, h_rise + 4, ok);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if ({pixel_count, line_count} !== 21'd0) begin n_fail++; $display("FAIL mid_counts: got %0d/%0d want 0/0", pixel_count, line_count); end
    n_chk++; if ({h_total, v_total} !== 21'd0) begin n_fail++; $display("FAIL mid_totals: got %0d/%0d want 0/0", h_total, v_total); end
    n_chk++; if ({locked, frame_start} !== 2'b00) begin n_fail++; $display("FAIL mid_flags: got %b want 00", {locked, frame_start}); end
    gen_en = 1'b0;
    repeat (5) @(negedge clk);
    test_lock("mid");
  endtask

`ifdef VGA_SYNC_POLARITY_DETECT_EN
  task automatic test_polarity();
    int n;
    rst_n = 1'b0; gen_en = 1'b0; neg = 1'b1; ht_req = HT0;
    repeat (5) @(negedge clk);
    n_chk++; if ({h_pol_low, v_pol_low} !== 2'b00) begin n_fail++; $display("FAIL pol_rst: got %b want 00", {h_pol_low, v_pol_low}); end
    rst_n = 1'b1; gen_en = 1'b1;
    n = 0;
    while (h_pol_low !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    n_chk++; if (h_pol_low !== 1'b1) begin n_fail++; $display("FAIL pol_h: got %b want 1", h_pol_low); end
    n = 0;
    while (v_pol_low !== 1'b1 && n < 1600) begin @(negedge clk); n++; end
    n_chk++; if (v_pol_low !== 1'b1) begin n_fail++; $display("FAIL pol_v: got %b want 1", v_pol_low); end
    n = 0;
    while (locked !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
    n_chk++; if (locked !== 1'b1) begin n_fail++; $display("FAIL pol_lock: got %b want 1", locked); end
    n_chk++; if ({h_total, v_total} !== {11'd40, 10'd12}) begin n_fail++; $display("FAIL pol_totals: got %0d/%0d want 40/12", h_total, v_total); end
  endtask
`endif

  initial begin
    test_reset();
    test_lock("lock");
    test_coincident();
    test_line_change();
    test_saturate();
    test_reset_mid();
`ifdef VGA_SYNC_POLARITY_DETECT_EN
    test_polarity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
